// File: rtl/rom_32x32.sv
// 32x32 constant lookup ROM with a registered read port (1-cycle latency).
// Define ROM_PARITY_EN to add a registered even-parity output, data_par.
module rom_32x32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  addr,
`ifdef ROM_PARITY_EN
    output logic        data_par,
`endif
    output logic [31:0] data_out
);

    logic [31:0] rom_word;

    // word(a) = 0x9E3779B9 * (a+1) mod 2^32
    always_comb begin
        rom_word = 32'h0000_0000;
        unique case (addr)
            5'd0:  rom_word = 32'h9E3779B9;
            5'd1:  rom_word = 32'h3C6EF372;
            5'd2:  rom_word = 32'hDAA66D2B;
            5'd3:  rom_word = 32'h78DDE6E4;
            5'd4:  rom_word = 32'h1715609D;
            5'd5:  rom_word = 32'hB54CDA56;
            5'd6:  rom_word = 32'h5384540F;
            5'd7:  rom_word = 32'hF1BBCDC8;
            5'd8:  rom_word = 32'h8FF34781;
            5'd9:  rom_word = 32'h2E2AC13A;
            5'd10: rom_word = 32'hCC623AF3;
            5'd11: rom_word = 32'h6A99B4AC;
            5'd12: rom_word = 32'h08D12E65;
            5'd13: rom_word = 32'hA708A81E;
            5'd14: rom_word = 32'h454021D7;
            5'd15: rom_word = 32'hE3779B90;
            5'd16: rom_word = 32'h81AF1549;
            5'd17: rom_word = 32'h1FE68F02;
            5'd18: rom_word = 32'hBE1E08BB;
            5'd19: rom_word = 32'h5C558274;
            5'd20: rom_word = 32'hFA8CFC2D;
            5'd21: rom_word = 32'h98C475E6;
            5'd22: rom_word = 32'h36FBEF9F;
            5'd23: rom_word = 32'hD5336958;
            5'd24: rom_word = 32'h736AE311;
            5'd25: rom_word = 32'h11A25CCA;
            5'd26: rom_word = 32'hAFD9D683;
            5'd27: rom_word = 32'h4E11503C;
            5'd28: rom_word = 32'hEC48C9F5;
            5'd29: rom_word = 32'h8A8043AE;
            5'd30: rom_word = 32'h28B7BD67;
            5'd31: rom_word = 32'hC6EF3720;
            default: rom_word = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out <= 32'h0000_0000;
        end else begin
            data_out <= rom_word;
        end
    end

`ifdef ROM_PARITY_EN
    // parity derived from the table word, not stored alongside it
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_par <= 1'b0;
        end else begin
            data_par <= ^rom_word;
        end
    end
`endif

endmodule

// File: tb/tb_rom_32x32.sv
// Self-checking bench for rom_32x32: vector table, sweep,
// latency/reset sequences and randomized traffic against a model.
module tb_rom_32x32;

    logic        clk;
    logic        reset;
    logic [4:0]  addr;
    logic [31:0] data_out;
`ifdef ROM_PARITY_EN
    logic        data_par;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    rom_32x32 dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
`ifdef ROM_PARITY_EN
        .data_par (data_par),
`endif
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic rst_n,
                                          input logic [4:0] a);
        logic [63:0] p;
        if (!rst_n) return 32'h0;
        p = 64'h9E3779B9 * (64'(a) + 64'd1);
        return p[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [31:0] exp);
        chk(name, data_out, exp);
`ifdef ROM_PARITY_EN
        chk({name, "_par"}, {31'b0, data_par}, {31'b0, ^exp});
`endif
    endtask

    // drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic r, input logic [4:0] a);
        @(negedge clk);
        reset = r;
        addr  = a;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic [4:0]  a;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset = 1'b0;
        addr  = 5'd0;

        vecs.push_back('{1'b0, 5'd5,  32'h00000000, "rst0"});
        vecs.push_back('{1'b0, 5'd5,  32'h00000000, "rst1"});
        vecs.push_back('{1'b0, 5'd5,  32'h00000000, "rst2"});
        vecs.push_back('{1'b1, 5'd0,  32'h9E3779B9, "release_a0"});
        vecs.push_back('{1'b1, 5'd1,  32'h3C6EF372, "a1"});
        vecs.push_back('{1'b1, 5'd2,  32'hDAA66D2B, "a2"});
        vecs.push_back('{1'b1, 5'd31, 32'hC6EF3720, "a31"});
        vecs.push_back('{1'b1, 5'd31, 32'hC6EF3720, "a31_hold"});
        vecs.push_back('{1'b1, 5'd15, 32'hE3779B90, "a15"});
        vecs.push_back('{1'b0, 5'd15, 32'h00000000, "rst_mid"});
        vecs.push_back('{1'b1, 5'd3,  32'h78DDE6E4, "a3"});

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].a);
            chk_out(vecs[i].name, vecs[i].exp);
        end

        // sequential sweep
        for (int a = 0; a < 32; a++) begin
            step(1'b1, 5'(a));
            chk_out($sformatf("sweep%0d", a), model(1'b1, 5'(a)));
        end

        // latency: addr change between edges must not reach data_out
        step(1'b1, 5'd1);
        @(negedge clk);
        addr = 5'd31;
        #1;
        chk_out("lat_hold", 32'h3C6EF372);
        @(posedge clk);
        #1;
        chk_out("lat_next", 32'hC6EF3720);

        // mid-stream reset during a sweep at addr=2
        step(1'b1, 5'd2);
        chk_out("mid_pre", 32'hDAA66D2B);
        step(1'b0, 5'd2);
        chk_out("mid_rst", 32'h00000000);
        step(1'b1, 5'd2);
        chk_out("mid_post", 32'hDAA66D2B);

        // randomized traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic [4:0] a;
            r = ($urandom_range(0, 15) != 0);
            a = 5'($urandom_range(0, 31));
            step(r, a);
            chk_out($sformatf("rnd%0d", i), model(r, a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
